// File: rtl/mux.sv
// Registered 4:1 word multiplexer with select-change pulse.
// Define MUX_PARITY_EN to add a registered even-parity output.
module mux #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [WIDTH-1:0] out,
  output logic             sel_chg
`ifdef MUX_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] word;
  logic [1:0]       sel_q;

  always_comb begin
    word = in1;
    unique case (select)
      2'd0: word = in1;
      2'd1: word = in2;
      2'd2: word = in3;
      2'd3: word = in4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= RST_VALUE;
      sel_q   <= 2'd0;
      sel_chg <= 1'b0;
    end else begin
      out     <= word;
      sel_q   <= select;
      sel_chg <= (select != sel_q);
    end
  end

`ifdef MUX_PARITY_EN
  // Computed from the same word as out so both land on the same edge.
  always_ff @(posedge clk) begin
    if (rst)
      parity <= ^RST_VALUE;
    else
      parity <= ^word;
  end
`endif

endmodule

// File: tb/tb_mux.sv
// Directed self-checking bench for mux.
// Parity checks are active when MUX_PARITY_EN is defined.
module tb_mux;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   select;
  logic [W-1:0] in1, in2, in3, in4;
  logic [W-1:0] out;
  logic         sel_chg;
`ifdef MUX_PARITY_EN
  logic         parity;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux #(.WIDTH(W), .RST_VALUE('0)) dut (
    .clk     (clk),
    .rst     (rst),
    .select  (select),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .in4     (in4),
    .out     (out),
    .sel_chg (sel_chg)
`ifdef MUX_PARITY_EN
    ,
    .parity  (parity)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] s,
                      input logic [W-1:0] e_out,
                      input logic e_chg,
                      input string tag);
    select = s;
    tick();
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".chg"}, 32'(sel_chg), 32'(e_chg));
  endtask

  initial begin
    rst    = 1'b1;
    select = 2'd0;
    in1    = 16'd11111;
    in2    = 16'd22222;
    in3    = 16'd33333;
    in4    = 16'd44444;
    #2;
    tick();
    chk("rst.out", 32'(out), 32'd0);
    chk("rst.chg", 32'(sel_chg), 32'd0);
`ifdef MUX_PARITY_EN
    chk("rst.par", 32'(parity), 32'd0);
`endif
    rst = 1'b0;

    step(2'd0, 16'd11111, 1'b0, "s0");
    step(2'd1, 16'd22222, 1'b1, "s1");
    step(2'd2, 16'd33333, 1'b1, "s2");
    step(2'd3, 16'd44444, 1'b1, "s3");
    step(2'd0, 16'd11111, 1'b1, "wrap");
    step(2'd2, 16'd33333, 1'b1, "to2");

    in3 = 16'd12345;
    step(2'd2, 16'd12345, 1'b0, "hold2");

    rst = 1'b1;
    step(2'd3, 16'd0, 1'b0, "midrst");
    rst = 1'b0;
    step(2'd3, 16'd44444, 1'b1, "postrst");

    in4 = 16'hFFFF;
    step(2'd3, 16'hFFFF, 1'b0, "full");

    in1 = 16'h0001;
    step(2'd0, 16'h0001, 1'b1, "p1");
`ifdef MUX_PARITY_EN
    chk("p1.par", 32'(parity), 32'd1);
`endif
    in1 = 16'h0003;
    step(2'd0, 16'h0003, 1'b0, "p3");
`ifdef MUX_PARITY_EN
    chk("p3.par", 32'(parity), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
